// File: rtl/ntt_k2_pkg.sv
// Shared types for the k2 (radix-2) order consumer: FSM states, the delay-line entry and default latencies.
// `D_width sets the AGU address width; it defaults to 6 when the build does not provide it.
`ifndef D_width
`define D_width 6
`endif

package ntt_k2_pkg;

  localparam int K2_D_WIDTH    = `D_width;
  localparam int K2_IDX_W      = K2_D_WIDTH - 1;
  localparam int K2_MEM_RD_LAT = 1;
  localparam int K2_BF_LAT     = 4;
  localparam int L             = K2_MEM_RD_LAT + K2_BF_LAT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } k2_state_e;

  // One in-flight butterfly pair: bank rows for both halves plus a valid flag.
  typedef struct packed {
    logic                valid;
    logic [K2_IDX_W-1:0] idx_0;
    logic [K2_IDX_W-1:0] idx_1;
  } k2_pair_t;

endpackage

// File: rtl/k2_order_rw_ctrl_if.sv
// AGU-side and memory-side signals of the k2 order consumer.
// master = the controller, slave = the AGU / memory / butterfly environment.
interface k2_order_rw_ctrl_if
  import ntt_k2_pkg::*;
#(
  parameter int D_WIDTH = K2_D_WIDTH
) ();

  logic               agu_enable;
  logic               agu_out_en;
  logic [D_WIDTH-1:0] order_0;
  logic [D_WIDTH-1:0] order_1;
  logic               agu_done;
  logic               rd_en;
  logic [D_WIDTH-2:0] rd_idx_0;
  logic [D_WIDTH-2:0] rd_idx_1;
  logic               bf_in_valid;
  logic               wr_en;
  logic [D_WIDTH-2:0] wr_idx_0;
  logic [D_WIDTH-2:0] wr_idx_1;

  modport master (
    input  agu_out_en, order_0, order_1, agu_done,
    output agu_enable, rd_en, rd_idx_0, rd_idx_1, bf_in_valid,
           wr_en, wr_idx_0, wr_idx_1
  );

  modport slave (
    output agu_out_en, order_0, order_1, agu_done,
    input  agu_enable, rd_en, rd_idx_0, rd_idx_1, bf_in_valid,
           wr_en, wr_idx_0, wr_idx_1
  );

endinterface

// File: rtl/k2_addr_delay_line.sv
// Shift register of k2 pairs, DEPTH entries deep, carrying read addresses to the write-back stage.
// Exposes the valid bit at tap TAP and an empty flag meaning "nothing valid remains after this edge".
module k2_addr_delay_line
  import ntt_k2_pkg::*;
#(
  parameter int DEPTH = L,
  parameter int TAP   = K2_MEM_RD_LAT
) (
  input  logic     clk,
  input  logic     rst,
  input  k2_pair_t din,
  output logic     tap_valid,
  output k2_pair_t dout,
  output logic     empty
);

  k2_pair_t line_q [DEPTH];
  k2_pair_t line_d [DEPTH];

  // NOTE: every variable in an always_comb gets a value on every path (default first), so no latch is inferred.
  always_comb begin
    line_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      line_d[i] = line_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: unlike a data RAM this storage is reset, because its valid bits gate the write strobe.
      for (int i = 0; i < DEPTH; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignment so each stage captures its neighbour's pre-edge value.
      line_q <= line_d;
    end
  end

  // The last entry leaves on this edge, so only the input and the earlier entries count.
  always_comb begin
    empty = !din.valid;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (line_q[i].valid) empty = 1'b0;
    end
  end

  assign tap_valid = line_q[TAP-1].valid;
  assign dout      = line_q[DEPTH-1];

endmodule

// File: rtl/k2_order_rw_ctrl.sv
// Last-stage (radix-2) NTT order consumer: accepts AGU pairs, reads both banks, writes back in place.
// Optional address checking is built only when K2_ADDR_CHECK_EN is defined; otherwise err is tied low.
module k2_order_rw_ctrl
  import ntt_k2_pkg::*;
#(
  parameter int D_WIDTH    = K2_D_WIDTH,
  parameter int N_PAIRS    = 16,
  parameter int MEM_RD_LAT = 1,
  parameter int BF_LAT     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  k2_order_rw_ctrl_if.master bus,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int DEPTH = MEM_RD_LAT + BF_LAT;
  localparam int CNT_W = $clog2(N_PAIRS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_PAIRS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PAIRS - 1);

  k2_state_e        state_q, state_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             done_q, done_d;
  k2_pair_t         acc_q, acc_d;
  k2_pair_t         wr_pair;
  logic             tap_valid;
  logic             line_empty;
  logic             accept;
  logic             last_accept;

  assign accept      = (state_q == ST_RUN) && bus.agu_out_en && (acc_cnt_q < CNT_MAX);
  assign last_accept = accept && (acc_cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    acc_cnt_d   = acc_cnt_q;
    done_d      = 1'b0;
    acc_d       = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          acc_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
          if (last_accept) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (line_empty) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Bank = address LSB, so the row for each bank is the address without it.
    if (accept) begin
      acc_d.valid = 1'b1;
      acc_d.idx_0 = bus.order_0[D_WIDTH-1:1];
      acc_d.idx_1 = bus.order_1[D_WIDTH-1:1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_cnt_q <= '0;
      done_q    <= 1'b0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      done_q    <= done_d;
      acc_q     <= acc_d;
    end
  end

  k2_addr_delay_line #(
    .DEPTH (DEPTH),
    .TAP   (MEM_RD_LAT)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .din       (acc_q),
    .tap_valid (tap_valid),
    .dout      (wr_pair),
    .empty     (line_empty)
  );

  assign bus.agu_enable  = (state_q == ST_RUN);
  assign bus.rd_en       = acc_q.valid;
  assign bus.rd_idx_0    = acc_q.idx_0;
  assign bus.rd_idx_1    = acc_q.idx_1;
  assign bus.bf_in_valid = tap_valid;
  assign bus.wr_en       = wr_pair.valid;
  assign bus.wr_idx_0    = wr_pair.idx_0;
  assign bus.wr_idx_1    = wr_pair.idx_1;
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;

`ifdef K2_ADDR_CHECK_EN
  logic err_q, err_d;
  logic pair_bad;
  logic early_done;

  assign pair_bad   = bus.order_0[0] || (bus.order_1 != bus.order_0 + D_WIDTH'(1));
  assign early_done = (state_q == ST_RUN) && bus.agu_done && !last_accept;

  // Sticky until reset; never feeds back into the data path.
  always_comb begin
    err_d = err_q;
    if ((accept && pair_bad) || early_done) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_chk;
  assign unused_chk = ^{bus.agu_done, bus.order_0[0], bus.order_1[0]};
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_k2_order_rw_ctrl.sv
// Directed bench for k2_order_rw_ctrl with N_PAIRS=4, MEM_RD_LAT=1, BF_LAT=4.
// Per-cycle vector tables cover full passes; hand sequences cover reset mid-pass and the address check.
module tb_k2_order_rw_ctrl;
  import ntt_k2_pkg::*;

  localparam int DW = K2_D_WIDTH;
  localparam int IW = DW - 1;
  localparam int OW = 7 + 4 * IW;
`ifdef K2_ADDR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct {
    logic          start;
    logic          en;
    logic          adone;
    int            pk;
    logic [OW-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, done, err;
  int   total = 0;
  int   bad   = 0;
  vec_t vq[$];

  k2_order_rw_ctrl_if #(.D_WIDTH(DW)) bus ();

  k2_order_rw_ctrl #(
    .D_WIDTH    (DW),
    .N_PAIRS    (4),
    .MEM_RD_LAT (1),
    .BF_LAT     (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Row indices only matter while their strobe is high.
  logic [OW-1:0] obs_v;
  logic [OW-1:0] raw_v;
  assign obs_v = {bus.agu_enable, bus.rd_en,
                  bus.rd_en ? bus.rd_idx_0 : IW'(0), bus.rd_en ? bus.rd_idx_1 : IW'(0),
                  bus.bf_in_valid, bus.wr_en,
                  bus.wr_en ? bus.wr_idx_0 : IW'(0), bus.wr_en ? bus.wr_idx_1 : IW'(0),
                  busy, done, err};
  assign raw_v = {bus.agu_enable, bus.rd_en, bus.rd_idx_0, bus.rd_idx_1,
                  bus.bf_in_valid, bus.wr_en, bus.wr_idx_0, bus.wr_idx_1,
                  busy, done, err};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic en, input int pk, input logic ad);
    start          = st;
    bus.agu_out_en = en;
    bus.order_0    = en ? DW'(2 * pk) : '0;
    bus.order_1    = en ? DW'(2 * pk + 1) : '0;
    bus.agu_done   = ad;
  endtask

  function automatic logic [OW-1:0] mk_exp(input logic ae, input logic re, input int ri,
                                           input logic bf, input logic we, input int wi,
                                           input logic by, input logic dn);
    logic [IW-1:0] r, w;
    r = IW'(ri);
    w = IW'(wi);
    return {ae, re, r, r, bf, we, w, w, by, dn, 1'b0};
  endfunction

  task automatic add(input logic st, input logic en, input int pk,
                     input logic ae, input logic re, input int ri, input logic bf,
                     input logic we, input int wi, input logic by, input logic dn);
    vec_t v;
    v.start = st;
    v.en    = en;
    v.pk    = pk;
    v.adone = 1'b0;
    v.exp   = mk_exp(ae, re, ri, bf, we, wi, by, dn);
    vq.push_back(v);
  endtask

  // Four consecutive pairs; variant 3 adds dropped extra pairs, variant 5 adds ignored starts and agu_done.
  task automatic build_pass(input int variant);
    int last;
    add(1'b1, variant == 3, 7,      0, 0, 0, 0, 0, 0, 0, 0);
    add(1'b0, 1'b1, 0,              1, 0, 0, 0, 0, 0, 1, 0);
    add(variant == 5, 1'b1, 1,      1, 1, 0, 0, 0, 0, 1, 0);
    add(1'b0, 1'b1, 2,              1, 1, 1, 1, 0, 0, 1, 0);
    add(1'b0, 1'b1, 3,              1, 1, 2, 1, 0, 0, 1, 0);
    last = vq.size() - 1;
    vq[last].adone = (variant == 5);
    add(1'b0, variant == 3, 4,      0, 1, 3, 1, 0, 0, 1, 0);
    add(1'b0, variant == 3, 5,      0, 0, 0, 1, 0, 0, 1, 0);
    add(variant == 5, 1'b0, 0,      0, 0, 0, 0, 1, 0, 1, 0);
    add(1'b0, 1'b0, 0,              0, 0, 0, 0, 1, 1, 1, 0);
    add(1'b0, 1'b0, 0,              0, 0, 0, 0, 1, 2, 1, 0);
    add(1'b0, 1'b0, 0,              0, 0, 0, 0, 1, 3, 1, 0);
    add(1'b0, 1'b0, 0,              0, 0, 0, 0, 0, 0, 0, 1);
    add(1'b0, 1'b0, 0,              0, 0, 0, 0, 0, 0, 0, 0);
    add(1'b0, 1'b0, 0,              0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Two idle cycles between the second and third pair must reappear on every strobe.
  task automatic build_gap();
    add(1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0,  1, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 1,  1, 1, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0,  1, 1, 1, 1, 0, 0, 1, 0);
    add(0, 0, 0,  1, 0, 0, 1, 0, 0, 1, 0);
    add(0, 1, 2,  1, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 3,  1, 1, 2, 0, 0, 0, 1, 0);
    add(0, 0, 0,  0, 1, 3, 1, 1, 0, 1, 0);
    add(0, 0, 0,  0, 0, 0, 1, 1, 1, 1, 0);
    add(0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0,  0, 0, 0, 0, 1, 2, 1, 0);
    add(0, 0, 0,  0, 0, 0, 0, 1, 3, 1, 0);
    add(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_table(input string tname);
    for (int i = 0; i < vq.size(); i++) begin
      check($sformatf("%s r%0d", tname, i), 32'(obs_v), 32'(vq[i].exp));
      drive(vq[i].start, vq[i].en, vq[i].pk, vq[i].adone);
      tick();
    end
    drive(1'b0, 1'b0, 0, 1'b0);
    vq.delete();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int wr_seen;
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 1'b0);
    tick();
    tick();
    check("reset_outputs", 32'(raw_v), 32'd0);
    rst = 1'b0;

    build_pass(1); run_table("basic");
    build_gap();   run_table("gap");
    build_pass(3); run_table("extra_pairs");
    build_pass(5); run_table("start_ignored");

    // Reset one cycle after the second read: no write-back for the in-flight pairs.
    drive(1'b1, 1'b0, 0, 1'b0); tick();
    drive(1'b0, 1'b1, 0, 1'b0); tick();
    drive(1'b0, 1'b1, 1, 1'b0); tick();
    check("second_read", 32'({bus.rd_en, bus.rd_idx_0, bus.rd_idx_1}), 32'({1'b1, IW'(1), IW'(1)}));
    drive(1'b0, 1'b1, 2, 1'b0); tick();
    rst = 1'b1;
    drive(1'b0, 1'b1, 3, 1'b0); tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 0, 1'b0);
    check("rst_mid_pass", 32'(raw_v), 32'd0);
    wr_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.wr_en) wr_seen++;
      tick();
    end
    check("no_wr_after_rst", 32'(wr_seen), 32'd0);
    build_pass(1); run_table("after_rst");

    // Address check: a mis-paired order and an early agu_done.
    pulse_rst();
    drive(1'b1, 1'b0, 0, 1'b0); tick();
    check("chk_run", 32'(bus.agu_enable), 32'd1);
    drive(1'b0, 1'b1, 0, 1'b0);
    bus.order_0 = DW'(2);
    bus.order_1 = DW'(4);
    tick();
    drive(1'b0, 1'b0, 0, 1'b0);
    check("bad_pair_err", 32'(err), 32'(EXP_ERR));
    check("bad_pair_read", 32'({bus.rd_en, bus.rd_idx_0, bus.rd_idx_1}), 32'({1'b1, IW'(1), IW'(2)}));
    repeat (3) tick();
    check("err_sticky", 32'(err), 32'(EXP_ERR));
    pulse_rst();
    check("err_cleared", 32'({busy, err}), 32'd0);
    drive(1'b1, 1'b0, 0, 1'b0); tick();
    drive(1'b0, 1'b0, 0, 1'b1); tick();
    drive(1'b0, 1'b0, 0, 1'b0);
    check("early_done_err", 32'(err), 32'(EXP_ERR));
    check("early_done_state", 32'({bus.agu_enable, busy}), 32'd3);
    pulse_rst();
    check("final_idle", 32'(raw_v), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/k2_order_rw_ctrl.md
# k2_order_rw_ctrl

Consumer of the last-stage (k2, radix-2) address-pair stream. Drives the AGU enable, accepts each `Order_0`/`Order_1` pair, issues the dual-bank read, and flags butterfly-input valid. It delays the same pair by the butterfly latency and issues the write-back, so the final NTT stage runs in place. It sits between the k2 AGU and the two data-memory banks / radix-2 butterfly.

## Interface
Parameters:
- `D_WIDTH`, `` `D_width ``: address width of AGU orders.
- `N_PAIRS`, 16: pairs consumed per pass (≥1).
- `MEM_RD_LAT`, 1: memory read latency in cycles (≥1).
- `BF_LAT`, 4: butterfly latency in cycles (≥0).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pass request; honoured only in IDLE.
- `agu_out_en` in 1: order pair valid this cycle.
- `order_0` in D_WIDTH: even-bank address from the AGU.
- `order_1` in D_WIDTH: odd-bank address from the AGU.
- `agu_done` in 1: AGU end-of-sweep pulse.
- `agu_enable` out 1: enables the AGU while in RUN.
- `rd_en` out 1: read strobe to both banks.
- `rd_idx_0` out D_WIDTH-1: bank-0 row, `order_0 >> 1`.
- `rd_idx_1` out D_WIDTH-1: bank-1 row, `order_1 >> 1`.
- `bf_in_valid` out 1: memory data valid at the butterfly input.
- `wr_en` out 1: write-back strobe to both banks.
- `wr_idx_0` out D_WIDTH-1: bank-0 write row.
- `wr_idx_1` out D_WIDTH-1: bank-1 write row.
- `busy` out 1: high in RUN or DRAIN.
- `done` out 1: one-cycle end-of-pass pulse.
- `err` out 1: sticky address-check error (see Configuration).

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on `start`.
  - RUN→DRAIN on the cycle the N_PAIRS-th pair is accepted.
  - DRAIN→IDLE when the delay line is empty; `done` pulses on that transition.
- `agu_enable` is high exactly in RUN and falls in the cycle after the last accept.
- Accept condition: RUN && `agu_out_en` && `acc_cnt < N_PAIRS`. `acc_cnt` is ceil(log2(N_PAIRS+1)) bits, cleared on entering RUN.
- Pairs arriving outside RUN or beyond N_PAIRS are dropped silently.
- Bank mapping: bank = address LSB, row = address >> 1 (order_0 is even, order_1 = order_0 + 1).
- Delay line: depth L = MEM_RD_LAT + BF_LAT; each entry is {valid, idx_0, idx_1}. Shifts every cycle, fed by the accept stage.
- `agu_done` does not change state; it is used only by the address check.
- `start` while busy is ignored.
- `rst` at any time:
  - FSM to IDLE, counter and delay line cleared.
  - All outputs 0, including sticky `err`.
  - No write-back is issued for in-flight pairs.

## Timing
- Reset values: every output is 0.
- `agu_enable` rises in the cycle after `start` is sampled in IDLE.
- Pair accepted at edge t:
  - `rd_en`/`rd_idx_*` valid in cycle t+1.
  - `bf_in_valid` in cycle t+1+MEM_RD_LAT.
  - `wr_en`/`wr_idx_*` in cycle t+1+L.
- `done` asserts in the cycle after the last `wr_en`. `busy` falls with `done`.
- Back-to-back accepts give back-to-back reads and writes; gaps in `agu_out_en` are reproduced exactly at the write side.
- No backpressure exists; the memory must accept one read and one write per cycle.

## Configuration
- `K2_ADDR_CHECK_EN` defined: on each accept, `err` sets if `order_0[0]!=0` or `order_1 != order_0+1`. `err` also sets if `agu_done` arrives in RUN before N_PAIRS accepts. `err` stays set until `rst`; data flow is unaffected.
- Undefined: `err` is tied to 0 and no check logic is built.

## Structure
- Package `ntt_k2_pkg`:
  - `k2_pair_t` struct {valid, idx_0, idx_1}.
  - Localparam L = MEM_RD_LAT + BF_LAT.
  - FSM state enum.
- Sub-module `k2_addr_delay_line`: parameterised shift register of `k2_pair_t`, depth L, synchronous reset. It reports `empty` and provides a tap at MEM_RD_LAT for `bf_in_valid`.

## Test plan
1. N_PAIRS=4, MEM_RD_LAT=1, BF_LAT=4; `start`, then pairs (0,1),(2,3),(4,5),(6,7) on consecutive cycles from t:
   - `rd_idx` 0,1,2,3 in t+1..t+4.
   - `bf_in_valid` in t+2..t+5.
   - `wr_idx` 0,1,2,3 in t+6..t+9.
   - `done` in t+10.
2. Same pairs with `agu_out_en` low for 2 cycles between pairs 2 and 3 → the identical 2-cycle gap appears on `rd_en`, `bf_in_valid` and `wr_en`.
3. Six pairs offered with N_PAIRS=4 → only the first four are read and written; `agu_enable` falls after the 4th accept.
4. `rst` one cycle after the 2nd read → all outputs 0 next cycle, no `wr_en` ever issued; a fresh `start` runs a full pass.
5. `start` pulsed in RUN and in DRAIN → ignored; exactly one `done`.
6. With `K2_ADDR_CHECK_EN`:
   - Pair (2,4) → `err`=1 from the next cycle until `rst`.
   - Valid pairs only → `err` stays 0.
